// File: rtl/led_scan_sequencer.sv
// led_scan_sequencer
// Double-buffered 6-row x 8-column, 2-bit-per-pixel LED frame. The front
// buffer is scanned out as 16-bit words over sclk/sdata/latch, in three
// brightness planes of six rows each. The host writes pixels into the back
// buffer and requests a swap, which takes effect at the next frame boundary.
//
// Optional feature macro: LED_SCAN_BLANK_EN. When it is defined, a blank
// 0x0000 word is shifted and latched before every data word to suppress
// ghosting.
//
// Write handshake: a pixel transfers on a rising clk edge where
// wr_valid && wr_ready. wr_ready is registered and drops only in the single
// cycle where swap_ack is high. The host may hold wr_valid and its data
// until it sees wr_ready high.
module led_scan_sequencer #(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_row,
  input  logic [2:0] wr_col,
  input  logic [1:0] wr_level,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       sclk,
  output logic       sdata,
  output logic       latch,
  output logic       frame_done,
  output logic [2:0] dbg_state_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_SHIFT_LO = 3'd2;
  localparam logic [2:0] S_SHIFT_HI = 3'd3;
  localparam logic [2:0] S_LATCH    = 3'd4;
  localparam logic [2:0] S_NEXT     = 3'd5;

  logic [DW-1:0] div_q;
  logic          tick;

  logic [2:0]  state_q, state_d;
  logic [3:0]  bit_q, bit_d;
  logic        lat_q, lat_d;
  logic [2:0]  row_q, row_d;
  logic [1:0]  plane_q, plane_d;
  logic        front_q, front_d;
  logic        pend_q, pend_d;
  logic [15:0] word_q, word_d;
  logic        sclk_q, sclk_d;
  logic        sdata_q, sdata_d;
  logic        latch_q, latch_d;
  logic        ack_q, ack_d;
  logic        fd_q, fd_d;
  logic        rdy_q, rdy_d;
`ifdef LED_SCAN_BLANK_EN
  logic        blank_q, blank_d;
`endif

  logic [1:0]  buf_q [2][6][8];
  logic [15:0] load_word;
  logic        wr_fire;

  assign tick        = (div_q == DIV_LAST);
  assign wr_fire     = wr_valid && rdy_q;
  assign wr_ready    = rdy_q;
  assign swap_ack    = ack_q;
  assign sclk        = sclk_q;
  assign sdata       = sdata_q;
  assign latch       = latch_q;
  assign frame_done  = fd_q;
  assign dbg_state_o = state_q;

  // Scan-tick divider: one-cycle strobe every CLK_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Word for the current row/plane, built from the front buffer.
  always_comb begin
    load_word       = '0;
    load_word[13:8] = 6'b000001 << row_q;
    for (int i = 0; i < 8; i++) begin
      load_word[i] = (buf_q[front_q][row_q][i] > plane_q);
    end
`ifdef LED_SCAN_BLANK_EN
    if (blank_q) load_word = '0;
`endif
  end

  // Scan FSM next state; outputs are computed for the state being entered.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    lat_d   = lat_q;
    row_d   = row_q;
    plane_d = plane_q;
    front_d = front_q;
    pend_d  = pend_q | swap_req;
    word_d  = word_q;
    sclk_d  = sclk_q;
    sdata_d = sdata_q;
    latch_d = latch_q;
    ack_d   = 1'b0;
    fd_d    = 1'b0;
    rdy_d   = 1'b1;
`ifdef LED_SCAN_BLANK_EN
    blank_d = blank_q;
`endif
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          state_d = S_LOAD;
`ifdef LED_SCAN_BLANK_EN
          blank_d = 1'b1;
`endif
        end
        S_LOAD: begin
          word_d  = load_word;
          bit_d   = 4'd0;
          sclk_d  = 1'b0;
          sdata_d = load_word[0];
          state_d = S_SHIFT_LO;
        end
        S_SHIFT_LO: begin
          sclk_d  = 1'b1;
          state_d = S_SHIFT_HI;
        end
        S_SHIFT_HI: begin
          sclk_d = 1'b0;
          if (bit_q == 4'd15) begin
            sdata_d = 1'b0;
            latch_d = 1'b1;
            lat_d   = 1'b0;
            state_d = S_LATCH;
          end else begin
            bit_d   = bit_q + 4'd1;
            sdata_d = word_q[bit_q + 4'd1];
            state_d = S_SHIFT_LO;
          end
        end
        S_LATCH: begin
          if (!lat_q) begin
            lat_d = 1'b1;
          end else begin
            lat_d   = 1'b0;
            latch_d = 1'b0;
            state_d = S_NEXT;
`ifdef LED_SCAN_BLANK_EN
            if (blank_q) begin
              blank_d = 1'b0;
              state_d = S_LOAD;
            end
`endif
          end
        end
        S_NEXT: begin
          state_d = S_LOAD;
`ifdef LED_SCAN_BLANK_EN
          blank_d = 1'b1;
`endif
          if (row_q == 3'd5) begin
            row_d = 3'd0;
            if (plane_q == 2'd2) begin
              plane_d = 2'd0;
              fd_d    = 1'b1;
              if (pend_q || swap_req) begin
                front_d = ~front_q;
                pend_d  = 1'b0;
                ack_d   = 1'b1;
                rdy_d   = 1'b0;
              end
            end else begin
              plane_d = plane_q + 2'd1;
            end
          end else begin
            row_d = row_q + 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Scan FSM, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      lat_q   <= 1'b0;
      row_q   <= '0;
      plane_q <= '0;
      front_q <= 1'b0;
      pend_q  <= 1'b0;
      word_q  <= '0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      latch_q <= 1'b0;
      ack_q   <= 1'b0;
      fd_q    <= 1'b0;
      rdy_q   <= 1'b1;
`ifdef LED_SCAN_BLANK_EN
      blank_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      lat_q   <= lat_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      front_q <= front_d;
      pend_q  <= pend_d;
      word_q  <= word_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      latch_q <= latch_d;
      ack_q   <= ack_d;
      fd_q    <= fd_d;
      rdy_q   <= rdy_d;
`ifdef LED_SCAN_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  // Pixel store: host writes land in the back buffer; rows 6-7 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 6; r++) begin
          for (int c = 0; c < 8; c++) begin
            buf_q[b][r][c] <= 2'd0;
          end
        end
      end
    end else if (wr_fire && (wr_row < 3'd6)) begin
      buf_q[~front_q][wr_row][wr_col] <= wr_level;
    end
  end

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Bench for led_scan_sequencer: random pixel writes and swaps, with every
// serial word reassembled from sclk/sdata/latch and compared to a frame model.
module tb_led_scan_sequencer;

  localparam int CLK_DIV = 2;
`ifdef LED_SCAN_BLANK_EN
  localparam int ROW_TICKS = 71;
  localparam int WPF       = 36;
  localparam bit BLANK     = 1'b1;
`else
  localparam int ROW_TICKS = 36;
  localparam int WPF       = 18;
  localparam bit BLANK     = 1'b0;
`endif
  localparam int FRAME_CYC = 18 * ROW_TICKS * CLK_DIV;

  logic       clk, rst_n;
  logic       wr_valid, wr_ready;
  logic [2:0] wr_row, wr_col;
  logic [1:0] wr_level;
  logic       swap_req, swap_ack;
  logic       sclk, sdata, latch, frame_done;
  logic [2:0] dbg_state;

  led_scan_sequencer #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_col(wr_col), .wr_level(wr_level),
    .swap_req(swap_req), .swap_ack(swap_ack),
    .sclk(sclk), .sdata(sdata), .latch(latch), .frame_done(frame_done),
    .dbg_state_o(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: pixel buffers, front index (flips on swap_ack)
  int mbuf [2][6][8];
  int mfront;

  // scoreboard
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int rd = 0;
  int fd_cyc_q[$];
  int fd_words_q[$];
  int ack_cyc_q[$];
  int cyc_n = 0;
  int stab_err = 0;
  int bad_bits = 0;

  int bitn, widx;
  logic [15:0] sh;
  logic prev_sclk, prev_latch, hold_sd;

  function automatic int dpos(input int k);
    return BLANK ? (2 * k + 1) : k;
  endfunction

  // expected word number n since reset, from the front frame contents
  function automatic logic [15:0] model_exp(input int n);
    int k, d, r;
    logic [15:0] w;
    w = '0;
    if (BLANK && (n % 2 == 0)) return w;
    k = BLANK ? ((n / 2) % 18) : (n % 18);
    d = k / 6;
    r = k % 6;
    w[8 + r] = 1'b1;
    for (int c = 0; c < 8; c++) if (mbuf[mfront][r][c] > d) w[c] = 1'b1;
    return w;
  endfunction

  // monitor: reassemble serial words, record pulses
  always @(negedge clk) begin
    cyc_n++;
    if (!rst_n) begin
      bitn = 0; widx = 0; mfront = 0; prev_sclk = 0; prev_latch = 0; sh = '0;
    end else begin
      if (sclk && !prev_sclk) begin
        if (bitn < 16) sh[bitn] = sdata;
        bitn++;
        hold_sd = sdata;
      end else if (sclk && (sdata !== hold_sd)) begin
        stab_err++;
      end
      if (latch && !prev_latch) begin
        got_q.push_back(sh);
        exp_q.push_back(model_exp(widx));
        if (bitn != 16) bad_bits++;
        bitn = 0;
        widx++;
      end
      if (frame_done) begin
        fd_cyc_q.push_back(cyc_n);
        fd_words_q.push_back(widx);
      end
      if (swap_ack) begin
        ack_cyc_q.push_back(cyc_n);
        mfront = 1 - mfront;
      end
      prev_sclk = sclk;
      prev_latch = latch;
    end
  end

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // driver tasks
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 8; c++) mbuf[b][r][c] = 0;
  endtask

  task automatic wait_fd(input int n);
    int target, t;
    target = fd_cyc_q.size() + n;
    t = 0;
    while (fd_cyc_q.size() < target && t < (n + 1) * FRAME_CYC) begin
      cyc();
      t++;
    end
    if (fd_cyc_q.size() < target) begin
      checks++; failures++;
      $display("FAIL frame_done_timeout got=%0d required=%0d", fd_cyc_q.size(), target);
    end
  endtask

  task automatic wait_ack(output bit ok);
    int t;
    t = 0;
    while (swap_ack !== 1'b1 && t < 2 * FRAME_CYC) begin
      cyc();
      t++;
    end
    ok = (swap_ack === 1'b1);
    if (!ok) begin
      checks++; failures++;
      $display("FAIL swap_ack_timeout got=0 required=1");
    end
  endtask

  task automatic write_px(input int r, input int c, input int l);
    int t;
    wr_row = 3'(r); wr_col = 3'(c); wr_level = 2'(l); wr_valid = 1'b1;
    t = 0;
    while (wr_ready !== 1'b1 && t < 10) begin
      cyc();
      t++;
    end
    if (r < 6) mbuf[1 - mfront][r][c] = l;
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_swap(output int at);
    at = fd_cyc_q.size();
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_level = '0; swap_req = 1'b0;
    clear_model();
    repeat (3) cyc();
    checks += 6;
    if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b required=0", sclk); end
    if (sdata !== 1'b0) begin failures++; $display("FAIL reset_sdata got=%b required=0", sdata); end
    if (latch !== 1'b0) begin failures++; $display("FAIL reset_latch got=%b required=0", latch); end
    if (swap_ack !== 1'b0) begin failures++; $display("FAIL reset_swap_ack got=%b required=0", swap_ack); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b required=0", frame_done); end
    if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b required=1", wr_ready); end
    rd = got_q.size();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_idle_frame();
    int base, fd0;
    base = got_q.size();
    fd0 = fd_cyc_q.size();
    wait_fd(2);
    if (fd_cyc_q.size() >= fd0 + 2) begin
      checks += 4;
      if (fd_words_q[fd0] != WPF) begin
        failures++; $display("FAIL first_frame_words got=%0d required=%0d", fd_words_q[fd0], WPF);
      end
      if (fd_cyc_q[fd0 + 1] - fd_cyc_q[fd0] != FRAME_CYC) begin
        failures++; $display("FAIL frame_period got=%0d required=%0d", fd_cyc_q[fd0 + 1] - fd_cyc_q[fd0], FRAME_CYC);
      end
      if (got_q[base + dpos(0)] !== 16'h0100) begin
        failures++; $display("FAIL first_word got=%h required=0100", got_q[base + dpos(0)]);
      end
      if (got_q[base + dpos(5)] !== 16'h2000) begin
        failures++; $display("FAIL row5_word got=%h required=2000", got_q[base + dpos(5)]);
      end
    end
    checks++;
    if (ack_cyc_q.size() != 0) begin failures++; $display("FAIL spurious_ack got=%0d required=0", ack_cyc_q.size()); end
    while (rd < got_q.size()) begin
      checks++;
      if (got_q[rd] !== exp_q[rd]) begin failures++; $display("FAIL idle_word[%0d] got=%h required=%h", rd, got_q[rd], exp_q[rd]); end
      rd++;
    end
  endtask

  task automatic test_write_swap();
    int fd_at_req, base, acks0;
    bit ok;
    wait_fd(1);
    acks0 = ack_cyc_q.size();
    write_px(2, 5, 2);
    repeat (50) cyc();
    pulse_swap(fd_at_req);
    wait_ack(ok);
    if (ok) begin
      checks += 2;
      if (frame_done !== 1'b1) begin failures++; $display("FAIL ack_with_frame_done got=%b required=1", frame_done); end
      if (fd_cyc_q.size() != fd_at_req + 1) begin
        failures++; $display("FAIL ack_frame got=%0d required=%0d", fd_cyc_q.size(), fd_at_req + 1);
      end
    end
    while (rd < got_q.size()) begin
      checks++;
      if (got_q[rd] !== exp_q[rd]) begin failures++; $display("FAIL pre_swap_word[%0d] got=%h required=%h", rd, got_q[rd], exp_q[rd]); end
      rd++;
    end
    base = got_q.size();
    wait_fd(1);
    checks++;
    if (ack_cyc_q.size() != acks0 + 1) begin failures++; $display("FAIL ack_count got=%0d required=%0d", ack_cyc_q.size(), acks0 + 1); end
    if (got_q.size() >= base + WPF) begin
      checks += 3;
      if (got_q[base + dpos(2)] !== 16'h0420) begin failures++; $display("FAIL row2_plane0 got=%h required=0420", got_q[base + dpos(2)]); end
      if (got_q[base + dpos(8)] !== 16'h0420) begin failures++; $display("FAIL row2_plane1 got=%h required=0420", got_q[base + dpos(8)]); end
      if (got_q[base + dpos(14)] !== 16'h0400) begin failures++; $display("FAIL row2_plane2 got=%h required=0400", got_q[base + dpos(14)]); end
    end
    while (rd < got_q.size()) begin
      checks++;
      if (got_q[rd] !== exp_q[rd]) begin failures++; $display("FAIL post_swap_word[%0d] got=%h required=%h", rd, got_q[rd], exp_q[rd]); end
      rd++;
    end
  endtask

  task automatic test_row_drop();
    int fd_at_req;
    bit ok;
    wait_fd(1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (wr_ready !== 1'b1) begin failures++; $display("FAIL row7_ready got=%b required=1", wr_ready); end
      write_px($urandom_range(6, 7), $urandom_range(0, 7), $urandom_range(1, 3));
    end
    pulse_swap(fd_at_req);
    wait_ack(ok);
    wait_fd(1);
    while (rd < got_q.size()) begin
      checks++;
      if (got_q[rd] !== exp_q[rd]) begin failures++; $display("FAIL row_drop_word[%0d] got=%h required=%h", rd, got_q[rd], exp_q[rd]); end
      rd++;
    end
  endtask

  task automatic test_random();
    int fd_at_req, n;
    bit ok;
    for (int round = 0; round < 3; round++) begin
      wait_fd(1);
      n = $urandom_range(20, 60);
      for (int k = 0; k < n; k++) begin
        write_px($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
        repeat ($urandom_range(0, 2)) cyc();
      end
      pulse_swap(fd_at_req);
      wait_ack(ok);
      wait_fd(1);
      while (rd < got_q.size()) begin
        checks++;
        if (got_q[rd] !== exp_q[rd]) begin failures++; $display("FAIL random_word[%0d] got=%h required=%h", rd, got_q[rd], exp_q[rd]); end
        rd++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int next_fd, fd_at_req;
    bit ok, exp_hit;
    wait_fd(1);
    next_fd = fd_cyc_q[fd_cyc_q.size() - 1] + FRAME_CYC;
    pulse_swap(fd_at_req);
    while (cyc_n < next_fd - 20) cyc();
    for (int k = 0; k < 40; k++) begin
      exp_hit = (cyc_n == next_fd);
      checks += 2;
      if (swap_ack !== exp_hit) begin failures++; $display("FAIL b2b_ack cyc=%0d got=%b required=%b", cyc_n, swap_ack, exp_hit); end
      if (wr_ready !== !exp_hit) begin failures++; $display("FAIL b2b_ready cyc=%0d got=%b required=%b", cyc_n, wr_ready, !exp_hit); end
      wr_valid = 1'b1;
      wr_row = 3'($urandom_range(0, 5));
      wr_col = 3'($urandom_range(0, 7));
      wr_level = 2'($urandom_range(0, 3));
      if (wr_ready === 1'b1) mbuf[1 - mfront][wr_row][wr_col] = int'(wr_level);
      cyc();
    end
    wr_valid = 1'b0;
    wait_fd(1);
    pulse_swap(fd_at_req);
    wait_ack(ok);
    wait_fd(1);
    while (rd < got_q.size()) begin
      checks++;
      if (got_q[rd] !== exp_q[rd]) begin failures++; $display("FAIL b2b_word[%0d] got=%h required=%h", rd, got_q[rd], exp_q[rd]); end
      rd++;
    end
  endtask

  task automatic test_reset_mid();
    int t, base;
    t = 0;
    while (!(sclk === 1'b1 && sdata === 1'b1) && t < FRAME_CYC) begin
      cyc();
      t++;
    end
    while (rd < got_q.size()) begin
      checks++;
      if (got_q[rd] !== exp_q[rd]) begin failures++; $display("FAIL pre_reset_word[%0d] got=%h required=%h", rd, got_q[rd], exp_q[rd]); end
      rd++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (sclk !== 1'b0) begin failures++; $display("FAIL mid_reset_sclk got=%b required=0", sclk); end
    if (sdata !== 1'b0) begin failures++; $display("FAIL mid_reset_sdata got=%b required=0", sdata); end
    if (latch !== 1'b0) begin failures++; $display("FAIL mid_reset_latch got=%b required=0", latch); end
    clear_model();
    repeat (3) cyc();
    base = got_q.size();
    rd = base;
    rst_n = 1'b1;
    wait_fd(1);
    if (got_q.size() >= base + WPF) begin
      checks += 2;
      if (got_q[base + dpos(0)] !== 16'h0100) begin failures++; $display("FAIL restart_word got=%h required=0100", got_q[base + dpos(0)]); end
      if (fd_words_q[fd_words_q.size() - 1] != WPF) begin
        failures++; $display("FAIL restart_frame_words got=%0d required=%0d", fd_words_q[fd_words_q.size() - 1], WPF);
      end
    end
    while (rd < got_q.size()) begin
      checks++;
      if (got_q[rd] !== exp_q[rd]) begin failures++; $display("FAIL restart_frame_word[%0d] got=%h required=%h", rd, got_q[rd], exp_q[rd]); end
      rd++;
    end
  endtask

  task automatic test_serial_form();
    checks += 2;
    if (stab_err != 0) begin failures++; $display("FAIL sdata_stable got=%0d required=0", stab_err); end
    if (bad_bits != 0) begin failures++; $display("FAIL bits_per_word got=%0d required=0", bad_bits); end
  endtask

  initial begin
    test_reset();
    test_idle_frame();
    test_write_swap();
    test_row_drop();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_serial_form();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
